// File: rtl/mac_rx_fcs_check.sv
// mac_rx_fcs_check: receive-side Ethernet FCS checker and stripper.
// Runs reflected CRC-32 over every accepted byte, FCS included, and checks the
// residue at s_tlast. A 4-byte delay line keeps the FCS out of the output
// stream. Runts, PHY errors and residue mismatches mark the frame bad on the
// last forwarded byte.
// Optional feature: define MAC_RX_FCS_ERR_CNT_EN to build the saturating CRC
// error counter. Without it, crc_err_cnt is tied to zero.
module mac_rx_fcs_check #(
    parameter int MIN_FRAME_LEN = 64,
    parameter int CNT_WIDTH     = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [7:0]           s_tdata,
    input  logic                 s_tvalid,
    output logic                 s_tready,
    input  logic                 s_tlast,
    input  logic                 s_tuser,
    output logic [7:0]           m_tdata,
    output logic                 m_tvalid,
    input  logic                 m_tready,
    output logic                 m_tlast,
    output logic                 m_tuser,
    output logic                 frame_good,
    output logic                 frame_bad,
    output logic [CNT_WIDTH-1:0] crc_err_cnt
);

    localparam logic [31:0] CRC_INIT    = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC_RESIDUE = 32'hDEBB_20E3;
    localparam logic [31:0] CRC_POLY_R  = 32'hEDB8_8320;
    localparam logic [10:0] LEN_MAX     = 11'd2047;
    localparam logic [31:0] MIN_LEN_U   = 32'(MIN_FRAME_LEN);
    localparam logic [2:0]  CNT_RUN     = 3'd4;

    // One byte of the LSB-first CRC-32 update
    function automatic logic [31:0] crc32_byte(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c ^ {24'd0, d};
        for (int unsigned i = 0; i < 8; i++) begin
            r = r[0] ? ((r >> 1) ^ CRC_POLY_R) : (r >> 1);
        end
        return r;
    endfunction

    logic [2:0]  count_q, count_d;
    logic [7:0]  buf_q [4];
    logic [7:0]  buf_d [4];
    logic [31:0] crc_q, crc_d;
    logic [10:0] len_q, len_d;
    logic        err_q, err_d;
    logic [7:0]  m_tdata_q, m_tdata_d;
    logic        m_tvalid_q, m_tvalid_d;
    logic        m_tlast_q, m_tlast_d;
    logic        m_tuser_q, m_tuser_d;
    logic        good_q, good_d;
    logic        bad_q, bad_d;

    logic        accept;
    logic [31:0] crc_nxt;
    logic [10:0] len_tot;
    logic        crc_bad;
    logic        err_now;
    logic        runt;
    logic        frm_bad;

    // Frame-level status of the byte currently offered on the input
    always_comb begin
        s_tready = (count_q != CNT_RUN) || !m_tvalid_q || m_tready;
        accept   = s_tvalid && s_tready;
        crc_nxt  = crc32_byte(crc_q, s_tdata);
        len_tot  = (len_q == LEN_MAX) ? LEN_MAX : (len_q + 11'd1);
        crc_bad  = (crc_nxt != CRC_RESIDUE);
        err_now  = err_q || s_tuser;
        runt     = ({21'd0, len_tot} < MIN_LEN_U);
        frm_bad  = crc_bad || err_now || runt;
    end

    // Next state for delay line, CRC, frame bookkeeping and output register
    always_comb begin
        count_d    = count_q;
        buf_d      = buf_q;
        crc_d      = crc_q;
        len_d      = len_q;
        err_d      = err_q;
        m_tdata_d  = m_tdata_q;
        m_tvalid_d = m_tvalid_q;
        m_tlast_d  = m_tlast_q;
        m_tuser_d  = m_tuser_q;
        good_d     = 1'b0;
        bad_d      = 1'b0;

        if (m_tvalid_q && m_tready) begin
            m_tvalid_d = 1'b0;
        end

        if (accept) begin
            // buf[3] is always the oldest byte; a plain shift also covers FILL
            buf_d[0] = s_tdata;
            buf_d[1] = buf_q[0];
            buf_d[2] = buf_q[1];
            buf_d[3] = buf_q[2];

            if (count_q == CNT_RUN) begin
                m_tdata_d  = buf_q[3];
                m_tvalid_d = 1'b1;
                m_tlast_d  = s_tlast;
                m_tuser_d  = s_tlast && frm_bad;
            end

            if (s_tlast) begin
                count_d = '0;
                crc_d   = CRC_INIT;
                len_d   = '0;
                err_d   = 1'b0;
                good_d  = (count_q == CNT_RUN) && !frm_bad;
                bad_d   = (count_q != CNT_RUN) || frm_bad;
            end else begin
                count_d = (count_q == CNT_RUN) ? CNT_RUN : (count_q + 3'd1);
                crc_d   = crc_nxt;
                len_d   = len_tot;
                err_d   = err_now;
            end
        end
    end

    // State registers, synchronous active-high reset
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q    <= '0;
            buf_q      <= '{default: '0};
            crc_q      <= CRC_INIT;
            len_q      <= '0;
            err_q      <= 1'b0;
            m_tdata_q  <= '0;
            m_tvalid_q <= 1'b0;
            m_tlast_q  <= 1'b0;
            m_tuser_q  <= 1'b0;
            good_q     <= 1'b0;
            bad_q      <= 1'b0;
        end else begin
            count_q    <= count_d;
            buf_q      <= buf_d;
            crc_q      <= crc_d;
            len_q      <= len_d;
            err_q      <= err_d;
            m_tdata_q  <= m_tdata_d;
            m_tvalid_q <= m_tvalid_d;
            m_tlast_q  <= m_tlast_d;
            m_tuser_q  <= m_tuser_d;
            good_q     <= good_d;
            bad_q      <= bad_d;
        end
    end

    assign m_tdata    = m_tdata_q;
    assign m_tvalid   = m_tvalid_q;
    assign m_tlast    = m_tlast_q;
    assign m_tuser    = m_tuser_q;
    assign frame_good = good_q;
    assign frame_bad  = bad_q;

`ifdef MAC_RX_FCS_ERR_CNT_EN
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

    // Saturating count of residue mismatches only
    always_comb begin
        cnt_d = cnt_q;
        if (accept && s_tlast && crc_bad && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Counter register
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign crc_err_cnt = cnt_q;
`else
    assign crc_err_cnt = '0;
`endif

endmodule

// File: doc/mac_rx_fcs_check.md
# mac_rx_fcs_check

Receive-side Ethernet FCS checker and stripper. It sits between the RX MAC byte stream (preamble/SFD already removed) and the frame buffer. It computes CRC-32 over each frame including its trailing 4-byte FCS, and removes the FCS from the output stream. On the last forwarded byte it flags the frame bad if the CRC residue is wrong, the frame is a runt, or the PHY signalled an error.

## Interface
Parameters:
- MIN_FRAME_LEN, 64: minimum legal frame length in bytes, FCS included.
- CNT_WIDTH, 16: width of the CRC error counter.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- s_tdata  in  8  input frame byte, first byte of frame first, LSB first on wire.
- s_tvalid  in  1  input byte valid.
- s_tready  out  1  input byte accepted when s_tvalid & s_tready.
- s_tlast  in  1  last byte of frame; this is the last FCS byte.
- s_tuser  in  1  PHY error on this byte.
- m_tdata  out  8  output payload byte.
- m_tvalid  out  1  output valid.
- m_tready  in  1  downstream ready.
- m_tlast  out  1  last payload byte of frame.
- m_tuser  out  1  frame bad; qualified only with m_tlast.
- frame_good  out  1  one-cycle pulse: frame passed all checks.
- frame_bad  out  1  one-cycle pulse: frame failed any check, or was dropped.
- crc_err_cnt  out  CNT_WIDTH  saturating count of CRC-residue failures.

## Operation
- CRC uses the reflected (LSB-first) CRC-32, polynomial 0x04C11DB7, initial value 0xFFFFFFFF, no output XOR.
- The CRC is updated with every accepted byte, FCS bytes included.
- Good frame: the internal CRC state after the s_tlast byte equals 0xDEBB20E3. The CRC is reloaded to 0xFFFFFFFF after s_tlast.
- A 4-byte delay buffer plus an output register hold the stream. The buffer state is count 0..4:
  - IDLE (count=0).
  - FILL (count 1..3).
  - RUN (count=4).
- FILL: accepted bytes enter the buffer and nothing is output.
- RUN: an accepted byte enters the buffer and the oldest buffered byte moves to the output register.
- s_tlast accepted in RUN: the byte moved to output gets m_tlast=1.
  - m_tuser = crc_bad | err_seen | runt.
  - The buffer (the 4 FCS bytes) is discarded and count returns to 0.
- s_tlast accepted with count<4 (frame of 4 bytes or fewer): nothing is output, frame_bad pulses, count returns to 0.
- err_seen is set by s_tuser on any accepted byte of the frame and cleared after s_tlast.
- The byte counter saturates at 2047. runt = (bytes including the last byte) < MIN_FRAME_LEN.
- crc_err_cnt increments only on a residue mismatch, not on runt or PHY error. It holds at all-ones.
- Reset mid-frame: the partial frame is dropped silently with no pulse. The next accepted byte starts a new frame.

## Timing
- Reset values: s_tready=1, m_tvalid=0, m_tlast=0, m_tuser=0, m_tdata=0, frame_good=0, frame_bad=0, crc_err_cnt=0, count=0, CRC=0xFFFFFFFF.
- s_tready = 1 when count<4, otherwise (!m_tvalid | m_tready). It is combinational.
- Latency: payload byte n appears on m_tdata the cycle after byte n+4 is accepted.
- Sustained throughput is 1 byte/cycle.
- m_tvalid, m_tdata, m_tlast and m_tuser hold stable while m_tvalid & !m_tready.
- m_tvalid drops the cycle after a handshake unless a new byte is loaded in the same cycle.
- A new frame may start the cycle after s_tlast. FILL does not need the output register, so a held last byte does not block refill until count reaches 4.
- frame_good and frame_bad are registered and pulse the cycle after s_tlast is accepted, independent of m_tready.
- The CRC check includes the s_tlast byte combinationally. The crc_err_cnt update is visible the cycle after s_tlast.

## Configuration
- MAC_RX_FCS_ERR_CNT_EN defined: the crc_err_cnt counter is implemented as above.
- Not defined: the counter logic is removed and crc_err_cnt is tied to 0. All other behaviour is unchanged.

## Test plan
- MIN_FRAME_LEN=13; send ASCII "123456789" then FCS bytes 26 39 F4 CB (s_tlast on CB), m_tready=1 -> out 31..39 with tlast on 0x39, m_tuser=0; frame_good pulses; crc_err_cnt=0.
- Same frame with the last FCS byte changed to CA -> payload identical, m_tuser=1 on 0x39, frame_bad pulses, crc_err_cnt=1.
- 60-byte payload with correct FCS under defaults, then the same payload and FCS truncated to 59 bytes -> first frame: 60 bytes out, m_tuser=0. Second frame: m_tuser=1, crc_err_cnt unchanged.
- Valid 64-byte frame with s_tuser=1 on byte 10 -> m_tuser=1 on the last payload byte, frame_bad pulses, crc_err_cnt unchanged.
- Random m_tready (50%) over back-to-back valid frames -> output bytes match input minus FCS, no loss or duplication, output stable while stalled.
- 3-byte frame -> no output beats, frame_bad pulses. Assert rst mid-frame at byte 20 -> m_tvalid=0 next cycle, no pulse; a following valid frame passes with m_tuser=0.
